// File: rtl/refill_mem_responder_if.sv
// Cache-to-memory refill bus: level request/address in, one-cycle-per-beat ack/data out.
interface refill_mem_responder_if #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_cc2mem;
  logic [ADR_WIDTH-1:0]  adr_cc2mem;
  logic                  ack_mem2cc;
  logic [DATA_WIDTH-1:0] dat_mem2cc;

  modport master (output req_cc2mem, output adr_cc2mem, input ack_mem2cc, input dat_mem2cc);
  modport slave  (input req_cc2mem, input adr_cc2mem, output ack_mem2cc, output dat_mem2cc);
endinterface

// File: rtl/refill_mem_responder.sv
// Refill responder: answers a request with WORDS_PER_LINE in-order beats from a preloadable RAM,
// first beat LATENCY cycles after accept; no backpressure, dropping req aborts the burst.
module refill_mem_responder #(
  parameter int ADR_WIDTH      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_AW         = 10,
  parameter int LATENCY        = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  refill_mem_responder_if.slave  bus,
  output logic                   busy,
  input  logic                   ld_en,
  input  logic [MEM_AW-1:0]      ld_adr,
  input  logic [DATA_WIDTH-1:0]  ld_dat
);
  localparam int LB = $clog2(WORDS_PER_LINE);
  localparam int LW = MEM_AW - LB;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t                state;
  logic [CW-1:0]         lat_cnt;
  logic [LB-1:0]         beat;
  logic [LW-1:0]         line;
  logic                  armed;
  logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];
  logic [MEM_AW-1:0]     rd_idx;
  logic                  unused_adr_bits;

  assign rd_idx = {line, beat};
  // Upper address bits alias and the word-in-line bits are replaced by the beat counter.
  assign unused_adr_bits = ^{bus.adr_cc2mem[ADR_WIDTH-1:MEM_AW+2], bus.adr_cc2mem[LB+1:0]};

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_adr] <= ld_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      lat_cnt        <= '0;
      beat           <= '0;
      line           <= '0;
      armed          <= 1'b1;
      busy           <= 1'b0;
      bus.ack_mem2cc <= 1'b0;
      bus.dat_mem2cc <= '0;
    end else begin
      if (!bus.req_cc2mem) armed <= 1'b1;
      case (state)
        S_IDLE: begin
          bus.ack_mem2cc <= 1'b0;
          bus.dat_mem2cc <= '0;
          if (bus.req_cc2mem && armed) begin
            state   <= S_WAIT;
            line    <= bus.adr_cc2mem[MEM_AW+1:LB+2];
            lat_cnt <= CW'(LATENCY - 1);
            beat    <= '0;
            armed   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!bus.req_cc2mem) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
            busy    <= 1'b0;
          end else if (lat_cnt == '0) begin
            state          <= S_BURST;
            bus.ack_mem2cc <= 1'b1;
            bus.dat_mem2cc <= mem[rd_idx];
            beat           <= beat + 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_BURST: begin
          // The beat counter wraps to zero once the last beat has been issued.
          if (!bus.req_cc2mem) begin
            state          <= S_IDLE;
            beat           <= '0;
            busy           <= 1'b0;
            bus.ack_mem2cc <= 1'b0;
            bus.dat_mem2cc <= '0;
          end else if (beat == '0) begin
            state          <= S_DONE;
            bus.ack_mem2cc <= 1'b0;
            bus.dat_mem2cc <= '0;
          end else begin
            bus.ack_mem2cc <= 1'b1;
            bus.dat_mem2cc <= mem[rd_idx];
            beat           <= beat + 1'b1;
          end
        end
        default: begin
          state          <= S_IDLE;
          busy           <= 1'b0;
          bus.ack_mem2cc <= 1'b0;
          bus.dat_mem2cc <= '0;
        end
      endcase
    end
  end
endmodule

// File: doc/refill_mem_responder.md
# refill_mem_responder

Synthesizable memory-side responder for the cache controller's refill interface. It answers each `req_cc2mem` with a burst of four acknowledged 32-bit words from an internal word-addressed RAM, after a programmable latency. It sits between the cache controller and the backing store, and doubles as the memory model for the cache controller benches. A preload port fills the RAM before and between refills.

## Interface
- `ADR_WIDTH`, 32: refill address width.
- `DATA_WIDTH`, 32: beat width.
- `WORDS_PER_LINE`, 4: beats per refill; a power of two.
- `MEM_AW`, 10: RAM word-address width (2^MEM_AW words).
- `LATENCY`, 2: cycles from request accept to first ack; minimum 1.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_cc2mem`  in  1  refill request, level, held by the cache for the burst.
- `adr_cc2mem`  in  ADR_WIDTH  refill byte address, valid while req is high.
- `ack_mem2cc`  out  1  beat valid, one cycle per beat.
- `dat_mem2cc`  out  DATA_WIDTH  beat data; zero when ack is low.
- `busy`  out  1  high in WAIT, BURST and DONE.
- `ld_en`  in  1  preload write strobe.
- `ld_adr`  in  MEM_AW  preload word address.
- `ld_dat`  in  DATA_WIDTH  preload data.

## Operation
- RAM index = `adr_cc2mem[MEM_AW+1:2]`. Upper address bits are ignored, so addresses alias modulo 2^MEM_AW words. Byte offset `[1:0]` is ignored.
- Line base = index with the low log2(WORDS_PER_LINE) bits cleared. Beats are returned in order base+0 .. base+WORDS_PER_LINE-1. There is no critical-word-first ordering.
- FSM states:
  - IDLE → WAIT when `req_cc2mem`=1 and `armed`=1. This edge captures the line base and loads the latency counter with LATENCY-1.
  - WAIT: the counter decrements each cycle. At zero → BURST with beat counter 0.
  - BURST: ack=1 with the word at base+beat. The beat counter increments and wraps at WORDS_PER_LINE. After the last beat → DONE.
  - DONE: ack=0 for one cycle, then → IDLE.
- `armed`: cleared on accept, set whenever `req_cc2mem` is sampled low. A request therefore re-triggers only after req has been low for at least one cycle. A req held high past DONE does not start a second burst.
- Abort: req sampled low in WAIT or BURST → IDLE on that edge. ack drops on the same edge and no further beats are issued.
- Preload: `ld_en`=1 writes `ld_dat` to `ld_adr` at the edge, in any state.
  - Reads are read-before-write: a beat fetched on the same edge as a preload to that word returns the old data.
  - Preload never stalls or alters the FSM.
- RAM contents are not reset.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - `ack_mem2cc`=0, `dat_mem2cc`=0, `busy`=0;
  - state IDLE, counters 0, `armed`=1.
- Reset mid-burst aborts immediately. The RAM keeps its contents.
- All outputs are registered.
- Accept at edge N. First ack is visible after edge N+LATENCY, with subsequent beats on consecutive cycles and no gaps.
  - The last beat is visible after edge N+LATENCY+WORDS_PER_LINE-1.
  - ack is low after edge N+LATENCY+WORDS_PER_LINE.
- Minimum request-to-request spacing: LATENCY+WORDS_PER_LINE+2 cycles, including DONE and one req-low cycle.
- `busy` rises after edge N and falls after the DONE cycle.

## Test plan
- **Basic refill.** Preload words 0x340..0x343 with 0xA0A0_0000..0xA0A0_0003. Request 0xFF07BD08 with LATENCY=2. Required: four consecutive acks starting 2 cycles after accept, data 0xA0A0_0000..0xA0A0_0003 in order, then ack=0 and `busy` falling after DONE.
- **Aliasing.** Request 0xA5552D0C on the same preload. Required: identical line 0x340..0x343, because the upper bits are ignored.
- **Held req.** Keep req high for 20 cycles after the last beat. Required: exactly 4 acks. Dropping req for 1 cycle and raising it again yields a new burst.
- **Abort.** Drop req after the 2nd beat. Required: ack=0 on the next edge, only 2 beats total, FSM in IDLE. The next request works normally.
- **Preload collision.** Preload 0x342 ← 0xDEAD_BEEF on the edge that fetches beat 2. Required: beat 2 = old value 0xA0A0_0002, and a following refill returns 0xDEAD_BEEF.
- **Reset mid-WAIT and mid-BURST.** Assert `rst`=0. Required: ack, dat and `busy` are 0 without waiting for a clock edge. After release, a refill returns the preloaded data unchanged.
